ahb_split_slave_ctrl: RTL and testbench

Slave-side SPLIT controller placed in front of a slow shared resource on the AHB bus. It generates the hsplitx vector that feeds the bus arbiter's hsplitx input. When the resource is busy it answers a selected non-locked transfer with a two-cycle SPLIT response and records the master that was split. Once the resource has gone idle, it releases all recorded masters with a one-cycle hsplitx pulse so the arbiter can re-grant them.

---
 rtl/ahb_split_slave_ctrl.sv | 68 ++++++
 tb/tb_ahb_split_slave_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ahb_split_slave_ctrl.sv
// ahb_split_slave_ctrl: AHB slave SPLIT controller that parks masters while the resource is busy and releases them via hsplitx.
module ahb_split_slave_ctrl #(
  parameter int NMST        = 5,
  parameter int WAIT_CYC    = 1,
  parameter int RELEASE_DLY = 2,
  parameter int CNT_W       = 4
) (
  input  logic            hclk,
  input  logic            hreset,
  input  logic            hsel,
  input  logic [1:0]      htrans,
  input  logic            hready_in,
  input  logic [NMST-1:0] hmaster,
  input  logic            hmastlock,
  input  logic            res_busy,
  output logic            hready_out,
  output logic [1:0]      hresp,
  output logic [NMST-1:0] hsplitx,
  output logic [NMST-1:0] split_pending,
  output logic            xfer_go
);
  typedef enum logic [2:0] {IDLE, WAIT, OKAY, SPLIT1, SPLIT2} state_t;
  state_t state, ns;
  logic [CNT_W-1:0] wcnt, wcnt_n, rcnt, rcnt_inc;
  logic [NMST-1:0] mst, new_split, rel;
  logic lock, start, wdone, accept;
  assign start     = hsel & htrans[1] & hready_in;
  assign accept    = start & (state != WAIT) & (state != SPLIT1);
  assign wcnt_n    = (wcnt == '0) ? '0 : wcnt - 1'b1;
  assign wdone     = (wcnt_n == '0) & (~res_busy | ~lock);
  assign rcnt_inc  = rcnt + 1'b1;
  // The pulse fires on the edge that completes RELEASE_DLY low cycles, so hsplitx lands exactly that many cycles after res_busy drops
  assign rel       = (~res_busy && split_pending != '0 && rcnt_inc == CNT_W'(RELEASE_DLY)) ? split_pending : '0;
  assign new_split = (state == SPLIT2) ? mst : '0;
  always_comb begin
    ns = IDLE;
    if (state == WAIT) ns = wdone ? OKAY : WAIT;
    else if (state == SPLIT1) ns = SPLIT2;
    else if (start) ns = (res_busy & ~hmastlock) ? SPLIT1 : ((WAIT_CYC == 0) ? OKAY : WAIT);
  end
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state         <= IDLE;
      hready_out    <= 1'b1;
      hresp         <= 2'b00;
      xfer_go       <= 1'b0;
      hsplitx       <= '0;
      split_pending <= '0;
      wcnt          <= '0;
      rcnt          <= '0;
      mst           <= '0;
      lock          <= 1'b0;
    end else begin
      state         <= ns;
      hready_out    <= ~(ns == WAIT || ns == SPLIT1);
      hresp         <= (ns == SPLIT1 || ns == SPLIT2) ? 2'b11 : 2'b00;
      xfer_go       <= ns == OKAY;
      hsplitx       <= rel;
      split_pending <= (split_pending & ~rel) | new_split;
      rcnt          <= (res_busy || split_pending == '0 || rel != '0) ? '0 : rcnt_inc;
      if (accept) begin
        mst  <= hmaster;
        lock <= hmastlock;
        wcnt <= CNT_W'(WAIT_CYC);
      end else if (state == WAIT) wcnt <= wcnt_n;
    end
  end
endmodule

// File: tb/tb_ahb_split_slave_ctrl.sv
// tb_ahb_split_slave_ctrl: directed test-plan scenarios plus random traffic checked against a transaction-level model.
module tb_ahb_split_slave_ctrl;
  localparam int N = 5, WC = 1, DLY = 2;
  logic hclk = 0, hreset = 1, hsel = 0, hready_in = 1, hmastlock = 0, res_busy = 0;
  logic [1:0] htrans = 0;
  logic [N-1:0] hmaster = 0;
  logic hready_out, xfer_go;
  logic [1:0] hresp;
  logic [N-1:0] hsplitx, split_pending;
  int errs = 0, checks = 0;
  bit m_waiting, m_lock, m_okay;
  int m_served, m_split, m_run;
  logic [N-1:0] m_mst, m_pend, m_pulse;

  ahb_split_slave_ctrl #(.NMST(N), .WAIT_CYC(WC), .RELEASE_DLY(DLY), .CNT_W(4)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .hready_in(hready_in),
    .hmaster(hmaster), .hmastlock(hmastlock), .res_busy(res_busy), .hready_out(hready_out),
    .hresp(hresp), .hsplitx(hsplitx), .split_pending(split_pending), .xfer_go(xfer_go)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_waiting = 0; m_lock = 0; m_okay = 0; m_served = 0; m_split = 0; m_run = 0;
    m_mst = 0; m_pend = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    logic start;
    logic [N-1:0] ns;
    start = hsel && htrans[1] && hready_in;
    ns = (m_split == 2) ? m_mst : '0;
    m_pulse = 0;
    if (res_busy || m_pend == 0) m_run = 0;
    else begin
      m_run++;
      if (m_run == DLY) begin m_pulse = m_pend; m_pend = 0; m_run = 0; end
    end
    m_pend |= ns;
    m_okay = 0;
    if (m_waiting) begin
      m_served++;
      if (m_served >= WC && (!res_busy || !m_lock)) begin m_waiting = 0; m_okay = 1; end
    end else if (m_split == 1) m_split = 2;
    else begin
      m_split = 0;
      if (start) begin
        m_mst = hmaster; m_lock = hmastlock;
        if (res_busy && !hmastlock) m_split = 1;
        else if (WC == 0) m_okay = 1;
        else begin m_waiting = 1; m_served = 0; end
      end
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    if (!hreset) model_step();
    @(negedge hclk);
    chk("hready_out", hready_out, !(m_waiting || m_split == 1));
    chk("hresp", hresp, (m_split != 0) ? 2'b11 : 2'b00);
    chk("xfer_go", xfer_go, m_okay);
    chk("hsplitx", hsplitx, m_pulse);
    chk("split_pending", split_pending, m_pend);
  endtask

  task automatic drive(input logic s, input logic [1:0] t, input logic [N-1:0] m, input logic l, input logic b);
    hsel = s; htrans = t; hmaster = m; hmastlock = l; res_busy = b; hready_in = 1;
  endtask

  task automatic do_reset();
    hreset = 1;
    #1;
    model_reset();
    chk("rst_rdy", hready_out, 1);
    chk("rst_resp", hresp, 0);
    chk("rst_go", xfer_go, 0);
    chk("rst_splitx", hsplitx, 0);
    chk("rst_pend", split_pending, 0);
    @(posedge hclk);
    @(negedge hclk);
    hreset = 0;
  endtask

  initial begin
    @(negedge hclk);
    do_reset();
    // Accepted transfer with one wait state
    drive(1, 2'b10, 5'b01000, 0, 0); cyc(); chk("t1_wait", hready_out, 0);
    drive(0, 0, 0, 0, 0); cyc(); chk("t1_go", {hready_out, hresp, xfer_go}, 4'b1001);
    cyc();
    // Split then release after DLY low cycles
    drive(1, 2'b10, 5'b00100, 0, 1); cyc(); chk("t2_split1", {hready_out, hresp}, 3'b011);
    drive(0, 0, 0, 0, 1); cyc(); chk("t2_split2", {hready_out, hresp}, 3'b111);
    cyc(); chk("t2_pend", split_pending, 5'b00100);
    drive(0, 0, 0, 0, 0); cyc(); chk("t2_early", hsplitx, 0);
    cyc(); chk("t2_rel", hsplitx, 5'b00100); chk("t2_clr", split_pending, 0);
    cyc(); chk("t2_once", hsplitx, 0);
    // Two masters split, held, released together
    drive(1, 2'b10, 5'b00001, 0, 1); cyc();
    drive(0, 0, 0, 0, 1); cyc();
    drive(1, 2'b11, 5'b10000, 0, 1); cyc();
    drive(0, 0, 0, 0, 1); cyc(); cyc();
    chk("t3_pend", split_pending, 5'b10001);
    repeat (4) cyc();
    drive(0, 0, 0, 0, 0); cyc(); cyc(); chk("t3_rel", hsplitx, 5'b10001);
    cyc();
    // Locked transfer never splits
    drive(1, 2'b10, 5'b00010, 1, 1); cyc();
    drive(0, 0, 0, 0, 1);
    repeat (4) begin cyc(); chk("t4_hold", {hready_out, hresp}, 3'b000); end
    drive(0, 0, 0, 0, 0); cyc(); chk("t4_go", {hready_out, hresp, xfer_go}, 4'b1001);
    cyc();
    // New split completing on the release edge
    drive(1, 2'b10, 5'b01000, 0, 1); cyc();
    drive(0, 0, 0, 0, 1); cyc(); cyc();
    drive(1, 2'b10, 5'b00010, 0, 1); cyc();
    drive(0, 0, 0, 0, 0); cyc(); cyc();
    chk("t5_rel", hsplitx, 5'b01000); chk("t5_pend", split_pending, 5'b00010);
    repeat (3) cyc();
    // Reset during SPLIT1 drops the pending master
    drive(1, 2'b10, 5'b00001, 0, 1); cyc();
    drive(0, 0, 0, 0, 1); cyc(); cyc();
    drive(1, 2'b10, 5'b00100, 0, 1); cyc(); chk("t6_split1", hresp, 2'b11);
    do_reset();
    drive(0, 0, 0, 0, 0);
    repeat (5) cyc();
    chk("t6_pend", split_pending, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      hsel = ($urandom % 4) != 0;
      htrans = 2'($urandom % 4);
      hready_in = ($urandom % 8) != 0;
      hmaster = ($urandom % 4 == 0) ? N'($urandom) : N'(1 << ($urandom % N));
      hmastlock = ($urandom % 5) == 0;
      if ($urandom_range(5) == 0) res_busy = ~res_busy;
      if ($urandom_range(299) == 0) do_reset();
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
